tick_gen_multi: RTL and testbench

Multi-channel programmable tick generator: the parametrised successor to the team's fixed 50 M-count display divider. Each of NCH channels counts `clk` cycles against its own runtime-loadable divisor and produces a 50 %-duty toggle output and a one-cycle strobe. Divisor updates are glitch-free, and a global clear phase-aligns all channels. It feeds the display-refresh, OTP-expiry and debounce timing in the authenticator.

---
 rtl/tick_gen_multi.sv | 128 ++++++++++++
 tb/tb_tick_gen_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator. Each channel divides clk_i by its own
// runtime-loadable divisor, producing a 50%-duty toggle and a one-cycle strobe.
// Divisor writes are staged in a shadow register and only take effect at a period
// boundary, so a running period is never truncated.
module tick_gen_multi #(
    parameter int unsigned NCH         = 4,
    parameter int unsigned CW          = 26,
    parameter int unsigned DEFAULT_DIV = 50_000_000,
    localparam int unsigned SW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NCH-1:0]  en_i,
    input  logic            sync_clr_i,
    input  logic            div_wr_i,
    input  logic [SW-1:0]   div_sel_i,
    input  logic [CW-1:0]   div_val_i,
    output logic            div_err_o,
    output logic [NCH-1:0]  tick_out_o,
    output logic [NCH-1:0]  pulse_out_o
);

    localparam logic [CW-1:0] DefDiv = CW'(DEFAULT_DIV);

    logic [CW-1:0]  ct_q  [NCH];
    logic [CW-1:0]  ct_d  [NCH];
    logic [CW-1:0]  div_q [NCH];
    logic [CW-1:0]  div_d [NCH];
    logic [CW-1:0]  shd_q [NCH];
    logic [CW-1:0]  shd_d [NCH];
    logic [NCH-1:0] pnd_q, pnd_d;
    logic [NCH-1:0] tick_q, tick_d;
    logic [NCH-1:0] pulse_q, pulse_d;
    logic           err_q, err_d;

    logic           wr_ok;
    logic           wr_hit;
    logic           wrap;

    // A write is accepted only for a non-zero divisor aimed at an existing channel.
    assign wr_ok = div_wr_i && (div_val_i != '0) && (32'(div_sel_i) < NCH);

    // Next-state for every channel: counting, wrap, staged divisor apply and clear.
    always_comb begin
        err_d  = div_wr_i && !wr_ok;
        wr_hit = 1'b0;
        wrap   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            ct_d[i]    = ct_q[i];
            div_d[i]   = div_q[i];
            shd_d[i]   = shd_q[i];
            pnd_d[i]   = pnd_q[i];
            tick_d[i]  = tick_q[i];
            pulse_d[i] = 1'b0;

            wr_hit = wr_ok && (div_sel_i == SW'(i));
            // >= rather than == so a divisor shrunk below the count still wraps.
            wrap   = en_i[i] && (ct_q[i] >= div_q[i] - CW'(1));

            if (sync_clr_i) begin
                ct_d[i]   = '0;
                tick_d[i] = 1'b0;
                pnd_d[i]  = 1'b0;
                if (wr_hit) begin
                    shd_d[i] = div_val_i;
                    div_d[i] = div_val_i;
                end else if (pnd_q[i]) begin
                    div_d[i] = shd_q[i];
                end
            end else begin
                if (en_i[i]) begin
                    if (wrap) begin
                        ct_d[i]    = '0;
                        pulse_d[i] = 1'b1;
                        tick_d[i]  = ~tick_q[i];
                    end else begin
                        ct_d[i] = ct_q[i] + CW'(1);
                    end
                end

                if (wr_hit) begin
                    shd_d[i] = div_val_i;
                    // Write landing on a wrap edge bypasses the shadow stage.
                    if (wrap) begin
                        div_d[i] = div_val_i;
                        pnd_d[i] = 1'b0;
                    end else begin
                        pnd_d[i] = 1'b1;
                    end
                end else if (pnd_q[i] && (wrap || !en_i[i])) begin
                    // An idle channel has no period to protect, so apply at once.
                    div_d[i] = shd_q[i];
                    pnd_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers, asynchronously reset to the default divisor.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NCH; i++) begin
                ct_q[i]  <= '0;
                div_q[i] <= DefDiv;
                shd_q[i] <= DefDiv;
            end
            pnd_q   <= '0;
            tick_q  <= '0;
            pulse_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                ct_q[i]  <= ct_d[i];
                div_q[i] <= div_d[i];
                shd_q[i] <= shd_d[i];
            end
            pnd_q   <= pnd_d;
            tick_q  <= tick_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    assign div_err_o   = err_q;
    assign tick_out_o  = tick_q;
    assign pulse_out_o = pulse_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Directed bench for tick_gen_multi with a 5-cycle default divisor. A second,
// three-channel instance exercises rejection of an out-of-range channel index.
module tb_tick_gen_multi;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned DEF = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     en;
    logic           sync_clr;
    logic           div_wr;
    logic [1:0]     div_sel;
    logic [CW-1:0]  div_val;
    logic           div_err;
    logic [3:0]     tick_out;
    logic [3:0]     pulse_out;

    logic           b_wr;
    logic [1:0]     b_sel;
    logic [CW-1:0]  b_val;
    logic           b_err;
    logic [2:0]     b_tick;
    logic [2:0]     b_pulse;

    int n_checks = 0;
    int n_errs   = 0;

    // Expected pulse/tick vectors for edges 13..19 after the clear-with-write.
    logic [3:0] p5 [7] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h1, 4'hE, 4'h1};
    logic [3:0] t5 [7] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'hE, 4'hF};

    tick_gen_multi #(
        .NCH         (NCH),
        .CW          (CW),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .sync_clr_i  (sync_clr),
        .div_wr_i    (div_wr),
        .div_sel_i   (div_sel),
        .div_val_i   (div_val),
        .div_err_o   (div_err),
        .tick_out_o  (tick_out),
        .pulse_out_o (pulse_out)
    );

    tick_gen_multi #(
        .NCH         (3),
        .CW          (CW),
        .DEFAULT_DIV (DEF)
    ) dut_b (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en[2:0]),
        .sync_clr_i  (sync_clr),
        .div_wr_i    (b_wr),
        .div_sel_i   (b_sel),
        .div_val_i   (b_val),
        .div_err_o   (b_err),
        .tick_out_o  (b_tick),
        .pulse_out_o (b_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, checks reset outputs, releases just after an edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 4'hF;
        sync_clr = 1'b0;
        div_wr   = 1'b0;
        div_sel  = '0;
        div_val  = '0;
        b_wr     = 1'b0;
        b_sel    = '0;
        b_val    = '0;
        step();
        step();
        check("rst pulse", pulse_out, 4'h0);
        check("rst tick", tick_out, 4'h0);
        check("rst err", div_err, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        // Default divisor: pulses at 5, 10, 15 and tick period 10.
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            step();
            check($sformatf("t1 pulse k%0d", k), pulse_out, (k % 5 == 0) ? 4'hF : 4'h0);
            check($sformatf("t1 tick k%0d", k), tick_out, ((k / 5) % 2 == 1) ? 4'hF : 4'h0);
        end

        // Deferred write to ch1 at ct=2: period finishes at 5, then every 3.
        do_reset();
        step();
        step();
        div_wr  = 1'b1;
        div_sel = 2'd1;
        div_val = 8'd3;
        for (int k = 3; k <= 15; k++) begin
            logic e1, eo;
            step();
            if (k == 3) begin
                div_wr = 1'b0;
                check("t2 err", div_err, 1'b0);
            end
            e1 = (k == 5) || (k > 5 && (k - 5) % 3 == 0);
            eo = (k % 5 == 0);
            check($sformatf("t2 pulse k%0d", k), pulse_out, {eo, eo, e1, eo});
        end

        // Rejected writes: zero divisor, then out-of-range channel on the 3-ch instance.
        do_reset();
        div_wr  = 1'b1;
        div_sel = 2'd2;
        div_val = 8'd0;
        step();
        div_wr = 1'b0;
        check("t3 err zero", div_err, 1'b1);
        step();
        check("t3 err clear", div_err, 1'b0);
        b_wr    = 1'b1;
        b_sel   = 2'd3;
        b_val   = 8'd7;
        div_wr  = 1'b1;
        div_sel = 2'd1;
        div_val = 8'd5;
        step();
        b_wr   = 1'b0;
        div_wr = 1'b0;
        check("t3 b err sel", b_err, 1'b1);
        check("t3 err valid", div_err, 1'b0);
        step();
        check("t3 b err clear", b_err, 1'b0);
        for (int k = 5; k <= 10; k++) begin
            step();
            check($sformatf("t3 pulse k%0d", k), pulse_out, (k % 5 == 0) ? 4'hF : 4'h0);
            check($sformatf("t3 b pulse k%0d", k), b_pulse, (k % 5 == 0) ? 3'h7 : 3'h0);
        end

        // Enable gating: ch2 disabled for edges 4..10 at ct=3, pulses 2 edges after.
        do_reset();
        step();
        step();
        step();
        en = 4'b1011;
        for (int k = 4; k <= 12; k++) begin
            step();
            if (k == 10) en = 4'hF;
            check($sformatf("t4 p2 k%0d", k), pulse_out[2], (k == 12));
            check($sformatf("t4 t2 k%0d", k), tick_out[2], (k >= 12));
            check($sformatf("t4 p0 k%0d", k), pulse_out[0], (k % 5 == 0));
        end

        // Clear with simultaneous write ch0=2: everything realigns.
        sync_clr = 1'b1;
        div_wr   = 1'b1;
        div_sel  = 2'd0;
        div_val  = 8'd2;
        for (int k = 13; k <= 19; k++) begin
            step();
            sync_clr = 1'b0;
            div_wr   = 1'b0;
            check($sformatf("t5 pulse k%0d", k), pulse_out, p5[k-13]);
            check($sformatf("t5 tick k%0d", k), tick_out, t5[k-13]);
        end

        // div=1 on ch3 via clear-with-write: strobe every cycle, tick every cycle.
        sync_clr = 1'b1;
        div_wr   = 1'b1;
        div_sel  = 2'd3;
        div_val  = 8'd1;
        step();
        sync_clr = 1'b0;
        div_wr   = 1'b0;
        check("t6 clr pulse", pulse_out, 4'h0);
        for (int k = 21; k <= 25; k++) begin
            step();
            check($sformatf("t6 p3 k%0d", k), pulse_out[3], 1'b1);
            check($sformatf("t6 t3 k%0d", k), tick_out[3], (k % 2 == 1));
            check($sformatf("t6 p0 k%0d", k), pulse_out[0], (k % 2 == 0));
        end

        // Async reset mid-period clears outputs without waiting for an edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7 async pulse", pulse_out, 4'h0);
        check("t7 async tick", tick_out, 4'h0);
        check("t7 async err", div_err, 1'b0);
        step();
        rst_n = 1'b1;

        // After reset ch3 is back to 5; a write on ch0's wrap edge applies at once.
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("t8 pulse k%0d", k), pulse_out, 4'h0);
        end
        div_wr  = 1'b1;
        div_sel = 2'd0;
        div_val = 8'd2;
        step();
        div_wr = 1'b0;
        check("t8 pulse k5", pulse_out, 4'hF);
        check("t8 err", div_err, 1'b0);
        for (int k = 6; k <= 9; k++) begin
            step();
            check($sformatf("t8 pulse k%0d", k), pulse_out, (k % 2 == 1) ? 4'h1 : 4'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
